// File: rtl/vin_sonar_multi.sv
// Multi-channel ultrasonic range finder: round-robin triggers, synchronised echo
// pulse-width measurement and per-channel distance/timeout/valid registers.

module vin_sonar_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

module vin_sonar_multi #(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 32,
   parameter int TRIGGER_LEN = 500,
   parameter int TIMEOUT     = 1000000,
   parameter int PERIOD      = 1250000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       echo,
   output logic [CHANNELS-1:0]       trigger,
   output logic [CHANNELS*WIDTH-1:0] distance,
   output logic [CHANNELS-1:0]       valid,
   output logic [CHANNELS-1:0]       timeout
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int SW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] LAST_SLOT = SW'(PERIOD - 1);
   localparam logic [SW-1:0] TRIG_END  = SW'(TRIGGER_LEN);
   localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);
   localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);

   typedef enum logic [1:0] {TRIG, WAIT_RISE, MEASURE, GAP} state_t;

   state_t                         state;
   logic [CW-1:0]                  ch;
   logic [SW-1:0]                  slot_cnt;
   logic [TW-1:0]                  timer;
   logic [WIDTH-1:0]               meas_cnt;
   logic                           echo_prev;
   logic [CHANNELS-1:0]            echo_s;
   logic [CHANNELS-1:0][WIDTH-1:0] dist_q;

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_lane
         vin_sonar_sync u_sync (.clk(clk), .rst(rst), .d(echo[g]), .q(echo_s[g]));
      end
   endgenerate

   assign distance = dist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= TRIG;
         ch        <= '0;
         slot_cnt  <= '0;
         timer     <= '0;
         meas_cnt  <= '0;
         echo_prev <= 1'b0;
         trigger   <= '0;
         valid     <= '0;
         timeout   <= '0;
         dist_q    <= '0;
      end else begin
         valid     <= '0;
         // Tracks the active channel continuously, so a level already high
         // when WAIT_RISE is entered never looks like a rising edge.
         echo_prev <= echo_s[ch];
         slot_cnt  <= (slot_cnt == LAST_SLOT) ? '0 : slot_cnt + 1'b1;

         case (state)
            TRIG: begin
               if (slot_cnt == TRIG_END) begin
                  trigger <= '0;
                  timer   <= '0;
                  state   <= WAIT_RISE;
               end else begin
                  trigger[ch] <= 1'b1;
               end
            end
            WAIT_RISE, MEASURE: begin
               // Timeout wins over an echo fall seen on the same cycle.
               if (timer == TMAX) begin
                  dist_q[ch]  <= '1;
                  timeout[ch] <= 1'b1;
                  valid[ch]   <= 1'b1;
                  state       <= GAP;
               end else begin
                  timer <= timer + 1'b1;
                  if (state == WAIT_RISE) begin
                     if (echo_s[ch] && !echo_prev) begin
                        meas_cnt <= WIDTH'(1);
                        state    <= MEASURE;
                     end
                  end else if (echo_s[ch]) begin
                     meas_cnt <= meas_cnt + 1'b1;
                  end else begin
                     dist_q[ch]  <= meas_cnt;
                     timeout[ch] <= 1'b0;
                     valid[ch]   <= 1'b1;
                     state       <= GAP;
                  end
               end
            end
            GAP: begin
               if (slot_cnt == LAST_SLOT) begin
                  ch    <= (ch == LAST_CH) ? '0 : ch + 1'b1;
                  state <= TRIG;
               end
            end
            default: state <= TRIG;
         endcase
      end
   end
endmodule
